// File: rtl/stream_turbo_encode_pkg.sv
// stream_turbo_encode_pkg: shared FSM states, output symbol indices and the RSC step function
// for the rate-1/3 turbo encoder (feedback 7, feedforward 5).
package stream_turbo_encode_pkg;

    typedef enum logic {LOAD, ENC} state_t;

    localparam int SYS  = 0;
    localparam int PAR1 = 1;
    localparam int PAR2 = 2;

    // nxt[1] is the feedback bit a = u^s1^s0
    typedef struct packed {
        logic       p;
        logic [1:0] nxt;
    } rsc_t;

    function automatic rsc_t rsc_step(input logic u, input logic [1:0] s);
        rsc_t r;
        logic a;
        a = u ^ s[1] ^ s[0];
        r.p = a ^ s[0];
        r.nxt = {a, s[1]};
        return r;
    endfunction

endpackage

// File: rtl/stream_turbo_encode_rsc.sv
// rsc_encode_step: one 4-state recursive systematic convolutional encoder with a registered state;
// term drives the input from the state so the encoder flushes back to (0,0).
module rsc_encode_step
    import stream_turbo_encode_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic init,
    input  logic term,
    input  logic u,
    output logic u_eff,
    output logic p
);

    logic [1:0] state;
    rsc_t       r;

    always_comb begin
        u_eff = term ? state[1] ^ state[0] : u;
        r = rsc_step(u_eff, state);
    end

    assign p = r.p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= '0;
        else if (init)
            state <= '0;
        else if (en)
            state <= r.nxt;
    end

endmodule

// File: rtl/stream_turbo_encode.sv
// stream_turbo_encode: buffers an N-bit block, then emits N+TAIL_BITS turbo symbols {p2,p1,sys}.
// Define STREAM_TURBO_ENCODE_PINGPONG_EN for two buffers so the next block loads during encoding.
module stream_turbo_encode
    import stream_turbo_encode_pkg::*;
#(
    parameter int N         = 29,
    parameter int P         = 3,
    parameter int TAIL_BITS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       x,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] y,
    output logic       out_first,
    output logic       out_last
);

    localparam int L  = N + TAIL_BITS;
    localparam int AW = $clog2(N);
    localparam int CW = $clog2(L);

    state_t        state_q, state_d;
    logic [AW-1:0] wr_cnt, addr, addr_nx;
    logic [AW:0]   addr_sum;
    logic [CW-1:0] sym;
    logic [N-1:0]  rbuf;
    logic          in_fire, out_fire, fill_done, last_sym, tail, ready_nxt;
    logic          ue1, ue2, p1, p2;

    assign in_fire   = in_valid & in_ready;
    assign fill_done = in_fire && wr_cnt == AW'(N - 1);
    assign out_valid = state_q == ENC;
    assign out_fire  = out_valid & out_ready;
    assign last_sym  = sym == CW'(L - 1);
    assign tail      = sym >= CW'(N);
    assign out_first = out_valid && sym == '0;
    assign out_last  = out_valid && last_sym;

`ifdef STREAM_TURBO_ENCODE_PINGPONG_EN
    logic [1:0][N-1:0] mem;
    logic [1:0]        full;
    logic              wr_sel, rd_sel, nxt_sel;

    assign in_ready  = !full[wr_sel];
    assign rbuf      = mem[rd_sel];
    // the block to encode next: the alternate buffer while encoding, the current one when idle
    assign nxt_sel   = state_q == ENC ? ~rd_sel : rd_sel;
    assign ready_nxt = full[nxt_sel] | (fill_done && wr_sel == nxt_sel);

    always_ff @(posedge clk)
        if (in_fire) mem[wr_sel][wr_cnt] <= x;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full   <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
        end else begin
            if (fill_done) begin
                full[wr_sel] <= 1'b1;
                wr_sel       <= ~wr_sel;
            end
            if (out_fire && last_sym) begin
                full[rd_sel] <= 1'b0;
                rd_sel       <= ~rd_sel;
            end
        end
    end
`else
    logic [N-1:0] mem;

    assign in_ready  = state_q == LOAD;
    assign rbuf      = mem;
    assign ready_nxt = fill_done;

    always_ff @(posedge clk)
        if (in_fire) mem[wr_cnt] <= x;
`endif

    always_comb begin
        addr_sum = {1'b0, addr} + (AW + 1)'(P);
        addr_nx  = addr_sum >= (AW + 1)'(N) ? AW'(addr_sum - (AW + 1)'(N)) : addr_sum[AW-1:0];
        state_d  = (state_q == LOAD || (out_fire && last_sym)) ? (ready_nxt ? ENC : LOAD) : state_q;
        y        = out_valid ? {p2, p1, ue1} : 3'b000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            wr_cnt  <= '0;
            sym     <= '0;
            addr    <= '0;
        end else begin
            state_q <= state_d;
            if (in_fire)
                wr_cnt <= fill_done ? '0 : wr_cnt + 1'b1;
            if (out_fire) begin
                sym  <= last_sym ? '0 : sym + 1'b1;
                addr <= last_sym ? '0 : addr_nx;
            end
        end
    end

    rsc_encode_step u_enc1 (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (out_fire),
        .init (out_fire && last_sym),
        .term (tail),
        .u    (rbuf[AW'(sym)]),
        .u_eff(ue1),
        .p    (p1)
    );

    rsc_encode_step u_enc2 (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (out_fire),
        .init (out_fire && last_sym),
        .term (tail),
        .u    (rbuf[addr]),
        .u_eff(ue2),
        .p    (p2)
    );

    // interleaved systematic bit is not transmitted
    logic unused_ue2;
    assign unused_ue2 = ue2;

endmodule

// File: tb/tb_stream_turbo_encode.sv
// tb_stream_turbo_encode: directed checks of the turbo encoder against hand values and a bit-level model.
// Exercises back-to-back streaming when STREAM_TURBO_ENCODE_PINGPONG_EN is defined.
module tb_stream_turbo_encode;

    localparam int N = 29;
    localparam int P = 3;
    localparam int T = 2;
    localparam int L = N + T;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       x = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [2:0] y;
    logic       out_first;
    logic       out_last;

    int n_assert = 0;
    int n_fail = 0;

    logic [2:0] got_y [2*L];
    logic       got_f [2*L];
    logic       got_l [2*L];
    int         got_t [2*L];
    logic [2:0] exp_y [2*L];
    logic [2:0] stall_y [3];
    logic       stall_v [3];

    stream_turbo_encode dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .x(x),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .out_first(out_first), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic model(input logic [N-1:0] b, input int base);
        logic [1:0] sa, sb;
        logic u1, u2, a1, a2;
        sa = 2'b00;
        sb = 2'b00;
        for (int i = 0; i < L; i++) begin
            if (i < N) begin
                u1 = b[i];
                u2 = b[(i * P) % N];
            end else begin
                u1 = sa[1] ^ sa[0];
                u2 = sb[1] ^ sb[0];
            end
            a1 = u1 ^ sa[1] ^ sa[0];
            a2 = u2 ^ sb[1] ^ sb[0];
            exp_y[base + i] = {a2 ^ sb[0], a1 ^ sa[0], u1};
            sa = {a1, sa[1]};
            sb = {a2, sb[1]};
        end
    endtask

    task automatic load_block(input logic [N-1:0] b, input int nb);
        int k = 0;
        int guard = 0;
        while (k < nb && guard < 500) begin
            @(negedge clk);
            guard++;
            if (in_ready) begin
                in_valid = 1'b1;
                x = b[k];
                k++;
            end else
                in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_assert++;
        if (k != nb) begin
            n_fail++;
            $display("FAIL load_timeout: accepted %0d bits, required %0d", k, nb);
        end
    endtask

    task automatic collect(input int cnt, input int stall_at, input int stall_len);
        int i = 0;
        int cyc = 0;
        int st = 0;
        while (i < cnt && cyc < 400) begin
            if (i == stall_at && st < stall_len) begin
                out_ready = 1'b0;
                stall_y[st] = y;
                stall_v[st] = out_valid;
                st++;
            end else begin
                out_ready = 1'b1;
                if (out_valid) begin
                    got_y[i] = y;
                    got_f[i] = out_first;
                    got_l[i] = out_last;
                    got_t[i] = cyc;
                    i++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b1;
        n_assert++;
        if (i != cnt) begin
            n_fail++;
            $display("FAIL collect_timeout: got %0d symbols, required %0d", i, cnt);
        end
    endtask

    task automatic test_reset();
        #2;
        n_assert++;
        if ({in_ready, out_valid, y, out_first, out_last} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, required 1000000", {in_ready, out_valid, y, out_first, out_last});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_all_zero();
        int nf = 0;
        int nl = 0;
        load_block('0, N);
`ifndef STREAM_TURBO_ENCODE_PINGPONG_EN
        n_assert++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL enc_in_ready: got %b, required 0", in_ready);
        end
        in_valid = 1'b1;
        x = 1'b1;
`endif
        collect(L, -1, 0);
        in_valid = 1'b0;
        x = 1'b0;
        for (int i = 0; i < L; i++) begin
            nf += int'(got_f[i]);
            nl += int'(got_l[i]);
            n_assert++;
            if (got_y[i] !== 3'b000) begin
                n_fail++;
                $display("FAIL zero_y[%0d]: got %b, required 000", i, got_y[i]);
            end
        end
        n_assert++;
        if (got_f[0] !== 1'b1 || nf != 1) begin
            n_fail++;
            $display("FAIL zero_first: got first0=%b count=%0d, required 1 and 1", got_f[0], nf);
        end
        n_assert++;
        if (got_l[L-1] !== 1'b1 || nl != 1) begin
            n_fail++;
            $display("FAIL zero_last: got last30=%b count=%0d, required 1 and 1", got_l[L-1], nl);
        end
        n_assert++;
        if ({in_ready, out_valid, y} !== 5'b10000) begin
            n_fail++;
            $display("FAIL zero_return_load: got %b, required 10000", {in_ready, out_valid, y});
        end
    endtask

    task automatic test_impulse0();
        logic [3:0] pat;
        logic [3:0] obs;
        pat = 4'b0111;
        model(29'd1, 0);
        load_block(29'd1, N);
        collect(L, -1, 0);
        for (int i = 0; i < 4; i++) obs[i] = got_y[i][1];
        n_assert++;
        if (obs !== pat) begin
            n_fail++;
            $display("FAIL imp0_par1: got %b (sym3..0), required %b", obs, pat);
        end
        n_assert++;
        if (got_y[0] !== 3'b111) begin
            n_fail++;
            $display("FAIL imp0_sym0: got %b, required 111", got_y[0]);
        end
        for (int i = 0; i < L; i++) begin
            n_assert++;
            if (got_y[i] !== exp_y[i]) begin
                n_fail++;
                $display("FAIL imp0_y[%0d]: got %b, required %b", i, got_y[i], exp_y[i]);
            end
        end
    endtask

    task automatic test_impulse1();
        int first2 = -1;
        model(29'd2, 0);
        load_block(29'd2, N);
        collect(L, -1, 0);
        for (int i = L - 1; i >= 0; i--) if (got_y[i][2]) first2 = i;
        n_assert++;
        if (first2 != 10) begin
            n_fail++;
            $display("FAIL imp1_par2_first: got %0d, required 10", first2);
        end
        n_assert++;
        if (got_y[0] !== 3'b000 || got_y[1] !== 3'b011) begin
            n_fail++;
            $display("FAIL imp1_head: got %b %b, required 000 011", got_y[0], got_y[1]);
        end
        for (int i = 0; i < L; i++) begin
            n_assert++;
            if (got_y[i] !== exp_y[i]) begin
                n_fail++;
                $display("FAIL imp1_y[%0d]: got %b, required %b", i, got_y[i], exp_y[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [N-1:0] b;
        for (int i = 0; i < N; i++) b[i] = ((i / 3) % 2) == 0;
        model(b, 0);
        load_block(b, N);
        collect(L, 5, 3);
        for (int s = 0; s < 3; s++) begin
            n_assert++;
            if (stall_v[s] !== 1'b1 || stall_y[s] !== exp_y[5]) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got v=%b y=%b, required v=1 y=%b", s, stall_v[s], stall_y[s], exp_y[5]);
            end
        end
        for (int i = 0; i < L; i++) begin
            n_assert++;
            if (got_y[i] !== exp_y[i]) begin
                n_fail++;
                $display("FAIL stall_y[%0d]: got %b, required %b", i, got_y[i], exp_y[i]);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        logic [N-1:0] b;
        b = 29'h0ABC_DE1;
        load_block(29'h1FFF_FFFF, 12);
        rst_n = 1'b0;
        #2;
        n_assert++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL midreset_outputs: got valid,ready=%b, required 01", {out_valid, in_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model(b, 0);
        load_block(b, N);
        collect(L, -1, 0);
        n_assert++;
        if (got_f[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_first: got %b, required 1", got_f[0]);
        end
        for (int i = 0; i < L; i++) begin
            n_assert++;
            if (got_y[i] !== exp_y[i]) begin
                n_fail++;
                $display("FAIL midreset_y[%0d]: got %b, required %b", i, got_y[i], exp_y[i]);
            end
        end
    endtask

`ifdef STREAM_TURBO_ENCODE_PINGPONG_EN
    task automatic test_back_to_back();
        logic [N-1:0] a, b;
        a = 29'h1234_567;
        b = 29'h0F0F_0F1;
        model(a, 0);
        model(b, L);
        load_block(a, N);
        fork
            load_block(b, N);
            collect(2 * L, -1, 0);
        join
        n_assert++;
        if (got_l[L-1] !== 1'b1 || got_f[L] !== 1'b1 || got_t[L] - got_t[L-1] != 1) begin
            n_fail++;
            $display("FAIL b2b_gap: got last=%b first=%b gap=%0d, required 1 1 1", got_l[L-1], got_f[L], got_t[L] - got_t[L-1]);
        end
        for (int i = 0; i < 2 * L; i++) begin
            n_assert++;
            if (got_y[i] !== exp_y[i]) begin
                n_fail++;
                $display("FAIL b2b_y[%0d]: got %b, required %b", i, got_y[i], exp_y[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_all_zero();
        test_impulse0();
        test_impulse1();
        test_stall();
        test_reset_mid_load();
`ifdef STREAM_TURBO_ENCODE_PINGPONG_EN
        test_back_to_back();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_turbo_encode.md
STREAM_TURBO_ENCODE -- requirements
Module: stream_turbo_encode

Interface
REQ-001 SHALL have parameter N, default 29, block length in information bits (prime).
REQ-002 SHALL have parameter P, default 3, interleaver multiplier (coprime to N).
REQ-003 SHALL have parameter TAIL_BITS, default 2, termination symbols per constituent encoder.
REQ-004 SHALL have ports: clk  in  1  clock; rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: in_valid  in  1  input bit valid; in_ready  out  1  input accepted when high with in_valid; x  in  1  information bit.
REQ-006 SHALL have ports: out_valid  out  1  symbol valid; out_ready  in  1  downstream accept; y  out  3  y[0] systematic, y[1] parity1, y[2] parity2.
REQ-007 SHALL have ports: out_first  out  1  first symbol of block; out_last  out  1  symbol N+TAIL_BITS-1.

Function
REQ-008 SHALL implement an FSM with states LOAD, ENC: LOAD accepts N bits into a buffer, ENC emits N+TAIL_BITS symbols.
REQ-009 SHALL assert in_ready in LOAD only (without ping-pong); bit k of block stored at buffer[k] on each in_valid&&in_ready.
REQ-010 SHALL enter ENC the cycle after the Nth bit is accepted; first out_valid in that cycle (latency 1 clk from last bit).
REQ-011 Each RSC SHALL be 4-state, feedback 7, feedforward 5: a = u^s1^s0, p = a^s0, next (s1,s0) = (a,s1); both start at (0,0) per block.
REQ-012 For symbol i<N: encoder 1 input u=buffer[i]; encoder 2 input u=buffer[pi(i)], pi(i)=(i*P) mod N; y={p2,p1,buffer[i]}.
REQ-013 pi(i) SHALL be generated by an incremental adder (addr += P, subtract N on overflow), no multiplier.
REQ-014 For i>=N (tail): each encoder input u=s1^s0 (forcing a=0); y[0]=encoder 1 tail input, y[1]=encoder 1 parity, y[2]=encoder 2 parity; both encoders end in (0,0).
REQ-015 Symbol counter and encoder states SHALL advance only on out_valid&&out_ready; y, out_first, out_last held stable while out_ready low.
REQ-016 out_first high with symbol 0 only; out_last high with symbol N+TAIL_BITS-1 only.
REQ-017 After out_last is accepted, return to LOAD (in_ready high next cycle); in_valid while in_ready low is ignored.
REQ-018 out_valid low in LOAD; y driven 0 when out_valid low.

Reset
REQ-019 rst_n low SHALL asynchronously force LOAD, counters 0, encoder states (0,0), out_valid/out_first/out_last 0, y 0, in_ready 1 (buffer contents unreset).
REQ-020 Reset mid-LOAD or mid-ENC SHALL discard the partial block; the next accepted bit is bit 0 of a new block.

Configuration
REQ-021 STREAM_TURBO_ENCODE_PINGPONG_EN defined: two buffers; in_ready stays high during ENC while the alternate buffer fills; ENC for the next block starts the cycle after both the current out_last is accepted and the next block is full (back-to-back blocks, no gap).
REQ-022 STREAM_TURBO_ENCODE_PINGPONG_EN undefined: single buffer, behaviour per REQ-009/REQ-017.

Structure
REQ-023 The shared turbo package SHALL hold the state enum (LOAD, ENC), the RSC step function (u, state -> a, p, next state), and the y index constants (SYS=0, PAR1=1, PAR2=2).
REQ-024 One sub-module rsc_encode_step (registered 2-bit state, enable, init, terminate inputs) SHALL be instantiated twice.

Verification
REQ-025 All-zero block, out_ready=1 -> 31 symbols all y=3'b000, out_first at symbol 0, out_last at symbol 30.
REQ-026 Bit 0 =1, others 0 -> y[1] symbols 0..3 = 1,1,1,0 (period-3 thereafter); y[2]=1 first at symbol 0 (pi(0)=0).
REQ-027 Bit 1 =1, others 0 -> y[2] first 1 at symbol 10 (3*10 mod 29 = 1); encoder 1 tail returns state (0,0) at symbol 30.
REQ-028 Pattern x[i]=((i/3)%2==0), out_ready low for 3 cycles at symbol 5 -> y/out_valid held, counter frozen, symbol sequence identical to out_ready=1 run.
REQ-029 rst_n pulsed low after 12 bits loaded -> out_valid 0, in_ready 1; next 29 bits encode as a fresh block matching the golden model.
REQ-030 With STREAM_TURBO_ENCODE_PINGPONG_EN, two blocks streamed back-to-back with in_valid=1, out_ready=1 -> second block out_first the cycle after the first out_last, no idle gap.
